// File: rtl/xillybus_lite_regs.sv
// xillybus_lite_regs: AXI4-Lite slave holding the control/status register bank
// (ID, CTRL, W1C IRQ_STATUS with mask, SCRATCH, DOORBELL).
// Optional feature macro: XILLYBUS_LITE_REGS_TIMESTAMP_EN adds a 64-bit cycle
// counter readable at TS_LO (0x18) / TS_HI (0x1C); without it those offsets
// are unmapped.
module xillybus_lite_regs #(
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] C_ID_VALUE         = 32'h58494C4C
) (
  input  logic                            bus_clk,
  input  logic                            bus_rst,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [7:0]                      irq_event,
  output logic [7:0]                      ctrl_out,
  output logic                            doorbell_pulse,
  output logic [31:0]                     doorbell_data,
  output logic                            host_interrupt
);

  localparam logic [6:0] IDX_ID       = 7'd0;
  localparam logic [6:0] IDX_CTRL     = 7'd1;
  localparam logic [6:0] IDX_STATUS   = 7'd2;
  localparam logic [6:0] IDX_MASK     = 7'd3;
  localparam logic [6:0] IDX_SCRATCH  = 7'd4;
  localparam logic [6:0] IDX_DOORBELL = 7'd5;
`ifdef XILLYBUS_LITE_REGS_TIMESTAMP_EN
  localparam logic [6:0] IDX_TS_LO    = 7'd6;
  localparam logic [6:0] IDX_TS_HI    = 7'd7;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

  w_state_t    w_state;
  r_state_t    r_state;
  logic [6:0]  wr_idx;
  logic [6:0]  rd_idx;
  logic        wr_en;
  logic        wr_mapped;
  logic [31:0] rd_data;
  logic        rd_err;
  logic [7:0]  irq_status;
  logic [7:0]  irq_mask;
  logic [7:0]  w1c_bits;
  logic [31:0] scratch;
  logic        unused_addr_bits;

`ifdef XILLYBUS_LITE_REGS_TIMESTAMP_EN
  logic [63:0] ts_count;
  logic [31:0] ts_shadow;
`endif

  // Only byte offsets [8:2] are decoded; remaining address bits are don't-care.
  assign wr_idx = S_AXI_AWADDR[8:2];
  assign rd_idx = S_AXI_ARADDR[8:2];
  assign unused_addr_bits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:9], S_AXI_AWADDR[1:0],
                              S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:9], S_AXI_ARADDR[1:0]};

  // Registers are updated from the live bus during W_ACK, where AW/W are held.
  assign wr_en = (w_state == W_ACK);

  // Write address decode: which offsets answer OKAY.
  always_comb begin
    wr_mapped = 1'b0;
    case (wr_idx)
      IDX_ID, IDX_CTRL, IDX_STATUS, IDX_MASK, IDX_SCRATCH, IDX_DOORBELL: wr_mapped = 1'b1;
`ifdef XILLYBUS_LITE_REGS_TIMESTAMP_EN
      IDX_TS_LO, IDX_TS_HI: wr_mapped = 1'b1;
`endif
      default: wr_mapped = 1'b0;
    endcase
  end

  // Write channel FSM: accept AW+W together, respond, fire doorbell.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      w_state        <= W_IDLE;
      S_AXI_AWREADY  <= 1'b0;
      S_AXI_WREADY   <= 1'b0;
      S_AXI_BVALID   <= 1'b0;
      S_AXI_BRESP    <= '0;
      doorbell_pulse <= 1'b0;
      doorbell_data  <= '0;
    end else begin
      doorbell_pulse <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            w_state       <= W_ACK;
          end
        end
        W_ACK: begin
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          S_AXI_BVALID  <= 1'b1;
          S_AXI_BRESP   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
          if (wr_idx == IDX_DOORBELL) begin
            doorbell_pulse <= 1'b1;
            doorbell_data  <= S_AXI_WDATA[31:0];
          end
          w_state <= W_RESP;
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Plain RW registers: CTRL and MASK on strobe 0, SCRATCH per byte lane.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      ctrl_out <= '0;
      irq_mask <= '0;
      scratch  <= '0;
    end else if (wr_en) begin
      if (wr_idx == IDX_CTRL && S_AXI_WSTRB[0]) ctrl_out <= S_AXI_WDATA[7:0];
      if (wr_idx == IDX_MASK && S_AXI_WSTRB[0]) irq_mask <= S_AXI_WDATA[7:0];
      if (wr_idx == IDX_SCRATCH) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (S_AXI_WSTRB[b]) scratch[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  assign w1c_bits = (wr_en && wr_idx == IDX_STATUS && S_AXI_WSTRB[0]) ? S_AXI_WDATA[7:0] : '0;

  // Interrupt status: clear first, then OR in new events so a same-cycle event wins.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) irq_status <= '0;
    else         irq_status <= (irq_status & ~w1c_bits) | irq_event;
  end

  // Registered combined interrupt toward the host.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) host_interrupt <= 1'b0;
    else         host_interrupt <= |(irq_status & irq_mask);
  end

  // Read mux; unmapped offsets return zero with an error flag.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_idx)
      IDX_ID:       rd_data = C_ID_VALUE;
      IDX_CTRL:     rd_data = {24'h0, ctrl_out};
      IDX_STATUS:   rd_data = {24'h0, irq_status};
      IDX_MASK:     rd_data = {24'h0, irq_mask};
      IDX_SCRATCH:  rd_data = scratch;
      IDX_DOORBELL: rd_data = '0;
`ifdef XILLYBUS_LITE_REGS_TIMESTAMP_EN
      IDX_TS_LO:    rd_data = ts_count[31:0];
      IDX_TS_HI:    rd_data = ts_shadow;
`endif
      default:      rd_err  = 1'b1;
    endcase
  end

  // Read channel FSM: ARREADY one cycle, then hold RDATA/RVALID until RREADY.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            S_AXI_ARREADY <= 1'b1;
            r_state       <= R_ACK;
          end
        end
        R_ACK: begin
          S_AXI_ARREADY <= 1'b0;
          S_AXI_RVALID  <= 1'b1;
          S_AXI_RDATA   <= rd_data;
          S_AXI_RRESP   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          r_state       <= R_DATA;
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef XILLYBUS_LITE_REGS_TIMESTAMP_EN
  // Free-running cycle counter; TS_LO reads snapshot the upper word for TS_HI.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      ts_count  <= '0;
      ts_shadow <= '0;
    end else begin
      ts_count <= ts_count + 64'd1;
      if (r_state == R_ACK && rd_idx == IDX_TS_LO) ts_shadow <= ts_count[63:32];
    end
  end
`endif

endmodule

// File: tb/tb_xillybus_lite_regs.sv
// Testbench for xillybus_lite_regs: table-driven register accesses plus
// hand-written sequences for handshake timing, interrupts and doorbell.
module tb_xillybus_lite_regs;

  logic        bus_clk;
  logic        bus_rst;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [7:0]  irq_event;
  logic [7:0]  ctrl_out;
  logic        doorbell_pulse;
  logic [31:0] doorbell_data;
  logic        host_interrupt;

  xillybus_lite_regs #(
    .C_S_AXI_ADDR_WIDTH(32),
    .C_S_AXI_DATA_WIDTH(32),
    .C_ID_VALUE(32'h58494C4C)
  ) dut (
    .bus_clk(bus_clk), .bus_rst(bus_rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .irq_event(irq_event), .ctrl_out(ctrl_out), .doorbell_pulse(doorbell_pulse),
    .doorbell_data(doorbell_data), .host_interrupt(host_interrupt)
  );

  typedef struct {
    string       name;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int db_count = 0;

  logic [1:0]  resp;
  logic [31:0] rd;
  logic [31:0] rd2;
  logic [31:0] rd_hi;
  vec_t        vecs[$];

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  // Count doorbell strobe cycles, sampled away from the active edge.
  always @(negedge bus_clk) if (doorbell_pulse) db_count++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lead, input int b_delay, output logic [1:0] bresp);
    int n;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < aw_lead; i++) begin
      @(negedge bus_clk);
      check("aw_waits_for_w", 64'(S_AXI_AWREADY), 64'd0);
    end
    S_AXI_WVALID = 1'b1;
    n = 0;
    do begin
      @(negedge bus_clk);
      n++;
    end while (!S_AXI_AWREADY && n < 20);
    check("aw_ready_latency", 64'(n), 64'd1);
    check("w_ready_with_aw", 64'(S_AXI_WREADY), 64'd1);
    @(negedge bus_clk);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("bvalid_rise_ready_fall", 64'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 64'b100);
    for (int i = 0; i < b_delay; i++) begin
      @(negedge bus_clk);
      check("bvalid_held", 64'(S_AXI_BVALID), 64'd1);
    end
    bresp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    @(negedge bus_clk);
    S_AXI_BREADY = 1'b0;
    check("bvalid_fall", 64'(S_AXI_BVALID), 64'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] rresp);
    int n;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin
      @(negedge bus_clk);
      n++;
    end while (!S_AXI_ARREADY && n < 20);
    S_AXI_ARVALID = 1'b0;
    do begin
      @(negedge bus_clk);
      n++;
    end while (!S_AXI_RVALID && n < 40);
    check("read_latency", 64'(n), 64'd2);
    data  = S_AXI_RDATA;
    rresp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    @(negedge bus_clk);
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    bus_rst       = 1'b1;
    S_AXI_AWADDR  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    irq_event     = '0;

    // Vector table: accesses applied in order, each with its expected result.
    vecs.push_back('{"ctrl_wr",        1'b1, 32'h04, 32'hFFFFFFA5, 4'b1111, 32'h0,        2'b00});
    vecs.push_back('{"ctrl_rd",        1'b0, 32'h04, 32'h0,        4'b0000, 32'h000000A5, 2'b00});
    vecs.push_back('{"ctrl_wr_nostrb", 1'b1, 32'h04, 32'h0000003C, 4'b1110, 32'h0,        2'b00});
    vecs.push_back('{"ctrl_rd_kept",   1'b0, 32'h04, 32'h0,        4'b0000, 32'h000000A5, 2'b00});
    vecs.push_back('{"scratch_wr_b3",  1'b1, 32'h10, 32'h11223344, 4'b1000, 32'h0,        2'b00});
    vecs.push_back('{"scratch_rd",     1'b0, 32'h10, 32'h0,        4'b0000, 32'h11AD00EF, 2'b00});
    vecs.push_back('{"id_wr_ro",       1'b1, 32'h00, 32'hFFFFFFFF, 4'b1111, 32'h0,        2'b00});
    vecs.push_back('{"id_rd_kept",     1'b0, 32'h00, 32'h0,        4'b0000, 32'h58494C4C, 2'b00});
    vecs.push_back('{"doorbell_rd",    1'b0, 32'h14, 32'h0,        4'b0000, 32'h0,        2'b00});
    vecs.push_back('{"unmapped_wr",    1'b1, 32'h40, 32'hFFFFFFFF, 4'b1111, 32'h0,        2'b10});
    vecs.push_back('{"unmapped_rd",    1'b0, 32'h40, 32'h0,        4'b0000, 32'h0,        2'b10});
    vecs.push_back('{"scratch_after",  1'b0, 32'h10, 32'h0,        4'b0000, 32'h11AD00EF, 2'b00});
    vecs.push_back('{"ctrl_alias_rd",  1'b0, 32'h10000005, 32'h0,  4'b0000, 32'h000000A5, 2'b00});
    vecs.push_back('{"mask_wr",        1'b1, 32'h0C, 32'hFFFFFF05, 4'b0001, 32'h0,        2'b00});
    vecs.push_back('{"mask_rd",        1'b0, 32'h0C, 32'h0,        4'b0000, 32'h00000005, 2'b00});
`ifdef XILLYBUS_LITE_REGS_TIMESTAMP_EN
    vecs.push_back('{"ts_lo_wr",       1'b1, 32'h18, 32'hFFFFFFFF, 4'b1111, 32'h0,        2'b00});
    vecs.push_back('{"ts_hi_wr",       1'b1, 32'h1C, 32'hFFFFFFFF, 4'b1111, 32'h0,        2'b00});
`else
    vecs.push_back('{"ts_lo_wr",       1'b1, 32'h18, 32'hFFFFFFFF, 4'b1111, 32'h0,        2'b10});
    vecs.push_back('{"ts_lo_rd",       1'b0, 32'h18, 32'h0,        4'b0000, 32'h0,        2'b10});
    vecs.push_back('{"ts_hi_rd",       1'b0, 32'h1C, 32'h0,        4'b0000, 32'h0,        2'b10});
`endif

    // Reset state.
    repeat (3) @(negedge bus_clk);
    check("reset_handshake", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                                  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}), 64'd0);
    check("reset_user", 64'({ctrl_out, doorbell_pulse, doorbell_data, host_interrupt}), 64'd0);
    bus_rst = 1'b0;
    @(negedge bus_clk);

    // ID read right after reset.
    axi_read(32'h00, rd, resp);
    check("id_data", 64'(rd), 64'h58494C4C);
    check("id_resp", 64'(resp), 64'd0);

    // SCRATCH partial-strobe write with AW leading W by three cycles.
    axi_write(32'h10, 32'hDEADBEEF, 4'b0101, 3, 0, resp);
    check("scratch_bresp", 64'(resp), 64'd0);
    axi_read(32'h10, rd, resp);
    check("scratch_strb_data", 64'(rd), 64'h00AD00EF);

    // Table-driven accesses.
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, (i % 3), resp);
        check({vecs[i].name, "_bresp"}, 64'(resp), 64'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        check({vecs[i].name, "_data"}, 64'(rd), 64'(vecs[i].exp_data));
        check({vecs[i].name, "_rresp"}, 64'(resp), 64'(vecs[i].exp_resp));
      end
    end
    check("ctrl_out", 64'(ctrl_out), 64'hA5);
    check("no_stray_doorbell", 64'(db_count), 64'd0);

    // Masked-off event sets status but not the interrupt.
    irq_event = 8'h02;
    @(negedge bus_clk);
    irq_event = 8'h00;
    @(negedge bus_clk);
    check("masked_irq_low", 64'(host_interrupt), 64'd0);

    // Enabled event: interrupt follows the status change one cycle later.
    irq_event = 8'h04;
    @(negedge bus_clk);
    irq_event = 8'h00;
    check("irq_lag", 64'(host_interrupt), 64'd0);
    @(negedge bus_clk);
    check("irq_raised", 64'(host_interrupt), 64'd1);
    axi_read(32'h08, rd, resp);
    check("status_set", 64'(rd), 64'h06);

    // W1C of bit 2 colliding with a fresh bit-2 event: set wins.
    S_AXI_AWADDR  = 32'h08;
    S_AXI_WDATA   = 32'h04;
    S_AXI_WSTRB   = 4'b0001;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    @(negedge bus_clk);
    check("collide_awready", 64'(S_AXI_AWREADY), 64'd1);
    irq_event = 8'h04;
    @(negedge bus_clk);
    irq_event     = 8'h00;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("collide_bvalid", 64'(S_AXI_BVALID), 64'd1);
    S_AXI_BREADY = 1'b1;
    @(negedge bus_clk);
    S_AXI_BREADY = 1'b0;
    axi_read(32'h08, rd, resp);
    check("collide_status", 64'(rd), 64'h06);
    check("collide_irq", 64'(host_interrupt), 64'd1);

    // W1C everything pending: interrupt drops.
    axi_write(32'h08, 32'h06, 4'b0001, 0, 0, resp);
    check("w1c_irq_low", 64'(host_interrupt), 64'd0);
    axi_read(32'h08, rd, resp);
    check("w1c_status", 64'(rd), 64'h00);

    // Doorbell fires regardless of WSTRB, one cycle only.
    axi_write(32'h14, 32'h12345678, 4'b0000, 0, 2, resp);
    check("doorbell_bresp", 64'(resp), 64'd0);
    check("doorbell_pulse_cycles", 64'(db_count), 64'd1);
    check("doorbell_data", 64'(doorbell_data), 64'h12345678);
    axi_read(32'h14, rd, resp);
    check("doorbell_read_zero", 64'(rd), 64'd0);

    // Unmapped read held under RREADY backpressure.
    S_AXI_ARADDR  = 32'h40;
    S_AXI_ARVALID = 1'b1;
    @(negedge bus_clk);
    check("bp_arready", 64'(S_AXI_ARREADY), 64'd1);
    S_AXI_ARVALID = 1'b0;
    @(negedge bus_clk);
    check("bp_arready_fall", 64'(S_AXI_ARREADY), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 64'({S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}), {29'd0, 3'b110, 32'd0});
      @(negedge bus_clk);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge bus_clk);
    S_AXI_RREADY = 1'b0;
    check("bp_rvalid_fall", 64'(S_AXI_RVALID), 64'd0);

`ifdef XILLYBUS_LITE_REGS_TIMESTAMP_EN
    // Reads are three cycles apart, so consecutive TS_LO reads differ by 6.
    axi_read(32'h18, rd, resp);
    check("ts_lo_resp", 64'(resp), 64'd0);
    axi_read(32'h1C, rd_hi, resp);
    check("ts_hi_resp", 64'(resp), 64'd0);
    check("ts_hi_shadow", 64'(rd_hi), 64'd0);
    axi_read(32'h18, rd2, resp);
    check("ts_lo_delta", 64'(rd2 - rd), 64'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
